// File: rtl/fpu_pkg.sv
// fpu_pkg: shared rounding-mode, fflags index and canonical qNaN definitions
package fpu_pkg;
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    DYN = 3'd7
  } rm_e;
  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;
  localparam logic [31:0] QNAN32 = 32'h7fc0_0000;
  localparam logic [63:0] QNAN64 = 64'h7ff8_0000_0000_0000;
  function automatic logic rm_legal(input logic [2:0] rm);
    return rm <= RMM;
  endfunction
endpackage

// File: rtl/fpu_tag_fifo.sv
// fpu_tag_fifo: in-order FIFO of in-flight tags, pointers wrap modulo DEPTH
module fpu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 5,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  // pointer and occupancy bookkeeping; push+pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop) rd <= nxt(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // tag storage, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues tagged FP ops to one fixed-latency FU and returns in-order results (optional FPU_ISSUE_WATCHDOG_EN)
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int N = 32,
  parameter int LAT = 3,
  parameter int DEPTH = 4,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_a,
  input  logic [N-1:0]    req_b,
  input  logic [2:0]      req_rm,
  input  logic [TAGW-1:0] req_tag,
  input  logic [2:0]      fcsr_frm,
  output logic            fu_valid,
  output logic [N-1:0]    fu_a,
  output logic [N-1:0]    fu_b,
  output logic [2:0]      fu_frm,
  input  logic [N-1:0]    fu_out,
  input  logic            fu_of,
  input  logic            fu_uf,
  input  logic            fu_nx,
  input  logic            fu_inv,
  input  logic            fu_ready,
  output logic            rsp_valid,
  output logic [N-1:0]    rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic [4:0]      rsp_flags,
  output logic            rsp_illegal,
  output logic [4:0]      fflags_acc,
  input  logic            fflags_clr,
  output logic            busy,
  output logic            proto_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [N-1:0] QNAN = (N == 64) ? N'(QNAN64) : N'(QNAN32);
  localparam logic [4:0] NV_FLAG = 5'b1 << NV;
  logic [2:0] rm_eff;
  logic legal, accept, push, ill_acc, pop, stray, force_ret, full, empty;
  logic [TAGW-1:0] head_tag;
  logic [CW-1:0] count;
  logic [4:0] fu_flags;
  assign rm_eff = (req_rm == DYN) ? fcsr_frm : req_rm;
  assign legal = rm_legal(rm_eff);
  // illegal ops only go when nothing is in flight so their response cannot overtake older results
  assign req_ready = !rst && (legal ? !full : empty);
  assign accept = req_valid && req_ready;
  assign push = accept && legal;
  assign ill_acc = accept && !legal;
  assign stray = fu_ready && empty;
  assign pop = (fu_ready && !empty) || force_ret;
  assign busy = count != '0;
  fpu_tag_fifo #(.DEPTH(DEPTH), .W(TAGW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(req_tag),
    .dout(head_tag),
    .full(full),
    .empty(empty),
    .count(count)
  );
`ifdef FPU_ISSUE_WATCHDOG_EN
  localparam int WW = $clog2(4 * LAT + 1);
  logic [WW-1:0] wd;
  assign force_ret = !empty && !fu_ready && (wd == WW'(4 * LAT - 1));
  // stall timer for the head entry, restarted by any FIFO movement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd <= '0;
    else if (push || pop) wd <= '0;
    else if (!empty) wd <= wd + 1'b1;
  end
`else
  assign force_ret = 1'b0;
`endif
  // map FU exception outputs onto the fflags layout; divide-by-zero never comes from this FU
  always_comb begin
    fu_flags = '0;
    fu_flags[NV] = fu_inv;
    fu_flags[DZ] = 1'b0;
    fu_flags[OF] = fu_of;
    fu_flags[UF] = fu_uf;
    fu_flags[NX] = fu_nx;
  end
  // single-cycle issue strobe with operands and resolved rounding mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_valid <= 1'b0;
      fu_a <= '0;
      fu_b <= '0;
      fu_frm <= '0;
    end else begin
      fu_valid <= push;
      if (push) begin
        fu_a <= req_a;
        fu_b <= req_b;
        fu_frm <= rm_eff;
      end
    end
  end
  // response register: illegal-rm bounce or retired FU result, never both in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_tag <= '0;
      rsp_flags <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      rsp_valid <= pop || ill_acc;
      if (ill_acc) begin
        rsp_data <= QNAN;
        rsp_tag <= req_tag;
        rsp_flags <= '0;
        rsp_illegal <= 1'b1;
      end else if (pop) begin
        rsp_data <= force_ret ? QNAN : fu_out;
        rsp_tag <= head_tag;
        rsp_flags <= force_ret ? NV_FLAG : fu_flags;
        rsp_illegal <= 1'b0;
      end
    end
  end
  // sticky flag accumulation and protocol error; a clear coinciding with a response keeps that response's flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
      fflags_acc <= '0;
    end else begin
      if (stray || force_ret) proto_err <= 1'b1;
      fflags_acc <= fflags_clr ? (rsp_valid ? rsp_flags : 5'd0) : (rsp_valid ? (fflags_acc | rsp_flags) : fflags_acc);
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: table-driven single-op vectors plus multi-cycle sequences against a fixed-latency FU model
module tb_fpu_issue_ctrl;
  localparam int N = 32;
  localparam int LAT = 3;
  localparam int DEPTH = 4;
  localparam int TAGW = 5;
  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  logic [N-1:0] req_a, req_b;
  logic [2:0] req_rm, fcsr_frm;
  logic [TAGW-1:0] req_tag;
  logic fu_valid;
  logic [N-1:0] fu_a, fu_b;
  logic [2:0] fu_frm;
  logic [N-1:0] fu_out;
  logic fu_of, fu_uf, fu_nx, fu_inv, fu_ready;
  logic rsp_valid;
  logic [N-1:0] rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic [4:0] rsp_flags;
  logic rsp_illegal;
  logic [4:0] fflags_acc;
  logic fflags_clr;
  logic busy, proto_err;
  fpu_issue_ctrl #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag), .fcsr_frm(fcsr_frm),
    .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b), .fu_frm(fu_frm),
    .fu_out(fu_out), .fu_of(fu_of), .fu_uf(fu_uf), .fu_nx(fu_nx), .fu_inv(fu_inv), .fu_ready(fu_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
    .rsp_illegal(rsp_illegal), .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
    .busy(busy), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a, b;
    logic [2:0] rm, frm;
    logic [4:0] tag;
    logic legal;
    logic [2:0] efrm;
    logic [31:0] fout;
    logic [3:0] ffl;
    logic [31:0] edata;
    logic [4:0] eflags;
  } vec_t;
  vec_t vec [9];
  int total = 0;
  int pass_cnt = 0;
  int fu_cnt = 0;
  logic [2:0] last_frm;
  logic [31:0] last_a;
  logic [LAT:0] vpipe = '0;
  logic fu_en = 1'b1;
  logic stray = 1'b0;
  logic [35:0] fu_q [$];
  logic [42:0] rq [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc();
    @(negedge clk);
    vpipe = {vpipe[LAT-1:0], fu_valid & fu_en};
    fu_ready = vpipe[LAT] | stray;
    stray = 1'b0;
    {fu_out, fu_inv, fu_of, fu_uf, fu_nx} = '0;
    if (vpipe[LAT] && fu_q.size() != 0) {fu_out, fu_inv, fu_of, fu_uf, fu_nx} = fu_q.pop_front();
    if (rsp_valid) rq.push_back({rsp_data, rsp_tag, rsp_flags, rsp_illegal});
    if (fu_valid) begin
      fu_cnt++;
      last_frm = fu_frm;
      last_a = fu_a;
    end
  endtask
  task automatic issue(input logic [4:0] tag, input logic [2:0] rm, input logic [31:0] fout, input logic [3:0] ffl);
    fu_q.push_back({fout, ffl});
    req_valid = 1'b1;
    req_tag = tag;
    req_rm = rm;
    req_a = {27'd0, tag};
    req_b = 32'h4000_0000;
    cyc();
    req_valid = 1'b0;
  endtask
  initial begin
    int lat, nxt, guard, stalls;
    logic rdy, found;
    logic [42:0] r;
    vec[0] = '{32'h3fc00000, 32'h40100000, 3'b000, 3'b010, 5'd7,  1'b1, 3'b000, 32'h40700000, 4'b0000, 32'h40700000, 5'b00000};
    vec[1] = '{32'h11111111, 32'h22222222, 3'b111, 3'b001, 5'd3,  1'b1, 3'b001, 32'h12345678, 4'b0001, 32'h12345678, 5'b00001};
    vec[2] = '{32'h33333333, 32'h44444444, 3'b111, 3'b101, 5'd9,  1'b0, 3'b000, 32'h0,        4'b0000, 32'h7fc00000, 5'b00000};
    vec[3] = '{32'h55555555, 32'h66666666, 3'b100, 3'b111, 5'd10, 1'b1, 3'b100, 32'hdeadbeef, 4'b0110, 32'hdeadbeef, 5'b00110};
    vec[4] = '{32'h77777777, 32'h88888888, 3'b101, 3'b000, 5'd11, 1'b0, 3'b000, 32'h0,        4'b0000, 32'h7fc00000, 5'b00000};
    vec[5] = '{32'h99999999, 32'haaaaaaaa, 3'b110, 3'b000, 5'd12, 1'b0, 3'b000, 32'h0,        4'b0000, 32'h7fc00000, 5'b00000};
    vec[6] = '{32'hbbbbbbbb, 32'hcccccccc, 3'b111, 3'b111, 5'd13, 1'b0, 3'b000, 32'h0,        4'b0000, 32'h7fc00000, 5'b00000};
    vec[7] = '{32'hdddddddd, 32'heeeeeeee, 3'b011, 3'b000, 5'd31, 1'b1, 3'b011, 32'hffc00000, 4'b1000, 32'hffc00000, 5'b10000};
    vec[8] = '{32'h01020304, 32'h05060708, 3'b010, 3'b110, 5'd0,  1'b1, 3'b010, 32'h00000001, 4'b1111, 32'h00000001, 5'b10111};
    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_rm = '0; req_tag = '0; fcsr_frm = '0;
    fflags_clr = 1'b0;
    {fu_out, fu_inv, fu_of, fu_uf, fu_nx, fu_ready} = '0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_fflags_acc", fflags_acc, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rq.delete();
      fu_cnt = 0;
      if (vec[i].legal) fu_q.push_back({vec[i].fout, vec[i].ffl});
      req_valid = 1'b1;
      req_a = vec[i].a; req_b = vec[i].b; req_rm = vec[i].rm; req_tag = vec[i].tag; fcsr_frm = vec[i].frm;
      #1;
      chk($sformatf("v%0d_req_ready", i), req_ready, 1);
      cyc();
      req_valid = 1'b0;
      lat = 1;
      while (rq.size() == 0 && lat < 10) begin
        cyc();
        lat++;
      end
      cyc();
      cyc();
      chk($sformatf("v%0d_rsp_count", i), rq.size(), 1);
      r = (rq.size() != 0) ? rq[0] : '0;
      chk($sformatf("v%0d_latency", i), lat, vec[i].legal ? 5 : 1);
      chk($sformatf("v%0d_fu_issues", i), fu_cnt, vec[i].legal ? 1 : 0);
      if (vec[i].legal) begin
        chk($sformatf("v%0d_fu_frm", i), last_frm, vec[i].efrm);
        chk($sformatf("v%0d_fu_a", i), last_a, vec[i].a);
      end
      chk($sformatf("v%0d_rsp_data", i), r[42:11], vec[i].edata);
      chk($sformatf("v%0d_rsp_tag", i), r[10:6], vec[i].tag);
      chk($sformatf("v%0d_rsp_flags", i), r[5:1], vec[i].eflags);
      chk($sformatf("v%0d_rsp_illegal", i), r[0], !vec[i].legal);
    end
    rq.delete();
    fu_cnt = 0;
    stalls = 0;
    nxt = 1;
    guard = 0;
    req_rm = 3'b000;
    fcsr_frm = 3'b000;
    for (int t = 1; t <= 6; t++) fu_q.push_back({32'h1000 + t, 4'b0000});
    while (nxt <= 6 && guard < 40) begin
      req_valid = 1'b1;
      req_tag = 5'(nxt);
      req_a = 32'h2000 + nxt;
      #1;
      rdy = req_ready;
      if (!rdy) stalls++;
      cyc();
      guard++;
      if (rdy) nxt++;
    end
    req_valid = 1'b0;
    while (rq.size() < 6 && guard < 60) begin
      cyc();
      guard++;
    end
    chk("b2b_rsp_count", rq.size(), 6);
    chk("b2b_stalls", stalls, 1);
    chk("b2b_fu_issues", fu_cnt, 6);
    for (int t = 0; t < 6; t++) begin
      r = (rq.size() > t) ? rq[t] : '0;
      chk($sformatf("b2b_tag%0d", t + 1), r[10:6], t + 1);
      chk($sformatf("b2b_data%0d", t + 1), r[42:11], 32'h1000 + t + 1);
    end
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    chk("acc_cleared", fflags_acc, 5'b00000);
    rq.delete();
    issue(5'd20, 3'b000, 32'ha, 4'b0001);
    issue(5'd21, 3'b000, 32'hb, 4'b1000);
    issue(5'd22, 3'b000, 32'hc, 4'b0100);
    found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin
      cyc();
      if (rsp_valid && rsp_tag == 5'd22) found = 1'b1;
    end
    chk("acc_op3_seen", found, 1);
    chk("acc_nx_inv", fflags_acc, 5'b10001);
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    chk("acc_clr_with_rsp", fflags_acc, 5'b00100);
    cyc();
    rq.delete();
    chk("stray_pre_busy", busy, 0);
    chk("stray_pre_proto", proto_err, 0);
    stray = 1'b1;
    cyc();
    cyc();
    chk("stray_no_rsp", rq.size(), 0);
    chk("stray_proto_err", proto_err, 1);
    issue(5'd1, 3'b000, 32'h1, 4'b0000);
    issue(5'd2, 3'b000, 32'h2, 4'b0000);
    issue(5'd3, 3'b000, 32'h3, 4'b0000);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy_async", busy, 0);
    chk("midrst_fu_valid", fu_valid, 0);
    vpipe = '0;
    fu_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    rq.delete();
    repeat (10) cyc();
    chk("midrst_no_rsp", rq.size(), 0);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_proto_clr", proto_err, 0);
`ifdef FPU_ISSUE_WATCHDOG_EN
    fu_en = 1'b0;
    rq.delete();
    req_valid = 1'b1;
    req_rm = 3'b000;
    req_tag = 5'd5;
    cyc();
    req_valid = 1'b0;
    lat = 1;
    while (rq.size() == 0 && lat < 30) begin
      cyc();
      lat++;
    end
    r = (rq.size() != 0) ? rq[0] : '0;
    chk("wd_latency", lat, 4 * LAT + 1);
    chk("wd_data", r[42:11], 32'h7fc00000);
    chk("wd_tag", r[10:6], 5'd5);
    chk("wd_flags", r[5:1], 5'b10000);
    chk("wd_proto_err", proto_err, 1);
    chk("wd_busy", busy, 0);
    fu_en = 1'b1;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
